// File: rtl/tlc_seq_param.sv
// tlc_seq_param: prescaled round-robin traffic-light sequencer
// over NCH toggle-latched request channels.
//
// Ports:
//   CK       in   clock, rising edge
//   RST      in   async reset, active-high
//   clr      in   sync clear of all state
//   tgl      in   [NCH]   per-channel toggle
//   phase_o  out  [2*NCH] 00 IDLE 01 GREEN 10 YELLOW 11 RED
//   active_o out  [NCH]   one-hot busy channel
//   tick_o   out          prescaler tick
//   req_o    out  [NCH]   latched request bits
//
// Build option: define TLC_TOG_CLEAR_EN to auto-clear a
// channel's request when its sequence completes.
module tlc_seq_param #(
   parameter int NCH      = 2,
   parameter int PRESCALE = 64,
   parameter int G_TICKS  = 4,
   parameter int Y_TICKS  = 1,
   parameter int R_TICKS  = 2,
   parameter int DW_W     = 4
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             clr,
   input  logic [NCH-1:0]   tgl,
   output logic [2*NCH-1:0] phase_o,
   output logic [NCH-1:0]   active_o,
   output logic             tick_o,
   output logic [NCH-1:0]   req_o
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [CW-1:0]   CNT_MAX = CW'(PRESCALE - 1);
   localparam logic [DW_W-1:0] G_LD    = DW_W'(G_TICKS - 1);
   localparam logic [DW_W-1:0] Y_LD    = DW_W'(Y_TICKS - 1);
   localparam logic [DW_W-1:0] R_LD    = DW_W'(R_TICKS - 1);
   localparam logic [IW-1:0]   LAST_CH = IW'(NCH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_GREEN  = 2'b01,
      S_YELLOW = 2'b10,
      S_RED    = 2'b11
   } state_t;

   state_t          r_state, w_state_nx;
   logic [CW-1:0]   r_cnt, w_cnt_nx;
   logic [NCH-1:0]  r_tog, w_tog_nx;
   logic [DW_W-1:0] r_dwell, w_dwell_nx;
   logic [IW-1:0]   r_gnt, w_gnt_nx;
   logic [IW-1:0]   r_rr, w_rr_nx;

   logic            w_tick;
   logic            w_any_req;
   logic            w_done;
   logic [IW-1:0]   w_pick;
   logic [IW-1:0]   w_idx;

   assign w_tick = (r_cnt == CNT_MAX) & ~clr;
   assign w_done = w_tick & (r_state == S_RED)
                 & (r_dwell == '0);

   // Scan downward so the last hit is the channel closest
   // at-or-after the round-robin pointer.
   always_comb begin
      w_any_req = 1'b0;
      w_pick    = r_rr;
      w_idx     = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         w_idx = IW'((int'(r_rr) + k) % NCH);
         if (r_tog[w_idx]) begin
            w_any_req = 1'b1;
            w_pick    = w_idx;
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_dwell_nx = r_dwell;
      w_gnt_nx   = r_gnt;
      w_rr_nx    = r_rr;
      w_cnt_nx   = (r_cnt == CNT_MAX) ? '0
                 : r_cnt + CW'(1);
      w_tog_nx   = r_tog ^ tgl;
`ifdef TLC_TOG_CLEAR_EN
      if (w_done)
         w_tog_nx[r_gnt] = tgl[r_gnt];
`endif
      if (w_tick) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  w_state_nx = S_GREEN;
                  w_dwell_nx = G_LD;
                  w_gnt_nx   = w_pick;
                  w_rr_nx    = (w_pick == LAST_CH) ? '0
                             : w_pick + IW'(1);
               end
            end
            S_GREEN: begin
               if (r_dwell != '0) begin
                  w_dwell_nx = r_dwell - DW_W'(1);
               end else begin
                  w_state_nx = S_YELLOW;
                  w_dwell_nx = Y_LD;
               end
            end
            S_YELLOW: begin
               if (r_dwell != '0) begin
                  w_dwell_nx = r_dwell - DW_W'(1);
               end else begin
                  w_state_nx = S_RED;
                  w_dwell_nx = R_LD;
               end
            end
            S_RED: begin
               if (r_dwell != '0)
                  w_dwell_nx = r_dwell - DW_W'(1);
               else
                  w_state_nx = S_IDLE;
            end
         endcase
      end
      if (clr) begin
         w_state_nx = S_IDLE;
         w_dwell_nx = '0;
         w_gnt_nx   = '0;
         w_rr_nx    = '0;
         w_cnt_nx   = '0;
         w_tog_nx   = '0;
      end
   end

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_tog   <= '0;
         r_dwell <= '0;
         r_gnt   <= '0;
         r_rr    <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_tog   <= w_tog_nx;
         r_dwell <= w_dwell_nx;
         r_gnt   <= w_gnt_nx;
         r_rr    <= w_rr_nx;
      end
   end

   always_comb begin
      phase_o  = '0;
      active_o = '0;
      for (int i = 0; i < NCH; i++) begin
         if (r_state != S_IDLE && r_gnt == IW'(i)) begin
            phase_o[2*i +: 2] = r_state;
            active_o[i]       = 1'b1;
         end
      end
   end

   assign tick_o = w_tick;
   assign req_o  = r_tog;

endmodule

// File: tb/tb_tlc_seq_param.sv
// tb_tlc_seq_param: directed scoreboard bench for tlc_seq_param
// (NCH=2 PRESCALE=4 G=2 Y=1 R=1); cycle 0 = first cycle after reset.
module tb_tlc_seq_param;

   logic       CK;
   logic       RST;
   logic       clr;
   logic [1:0] tgl;
   logic [3:0] phase_o;
   logic [1:0] active_o;
   logic       tick_o;
   logic [1:0] req_o;

`ifdef TLC_TOG_CLEAR_EN
   localparam bit CE = 1'b1;
`else
   localparam bit CE = 1'b0;
`endif

   tlc_seq_param #(
      .NCH(2), .PRESCALE(4), .G_TICKS(2),
      .Y_TICKS(1), .R_TICKS(1), .DW_W(4)
   ) dut (
      .CK(CK), .RST(RST), .clr(clr), .tgl(tgl),
      .phase_o(phase_o), .active_o(active_o),
      .tick_o(tick_o), .req_o(req_o)
   );

   typedef struct {
      int         cyc;
      string      nm;
      logic [3:0] ph;
      logic [1:0] act;
      logic [1:0] req;
      logic       tk;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   initial CK = 1'b0;
   always #5 CK = ~CK;

   always @(posedge CK or posedge RST) begin
      if (RST) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Monitor: compares the queued expectation for this cycle.
   always @(negedge CK) begin
      if (q.size() != 0) begin
         if (q[0].cyc == cyc) begin
            checks = checks + 1;
            if ({phase_o, active_o, req_o, tick_o} !==
                {q[0].ph, q[0].act, q[0].req, q[0].tk}) begin
               errors = errors + 1;
               $display("FAIL %s c%0d got ph=%b act=%b req=%b tk=%b want ph=%b act=%b req=%b tk=%b",
                  q[0].nm, cyc, phase_o, active_o, req_o, tick_o,
                  q[0].ph, q[0].act, q[0].req, q[0].tk);
            end
            void'(q.pop_front());
         end else if (q[0].cyc < cyc) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s missed c%0d now c%0d",
               q[0].nm, q[0].cyc, cyc);
            void'(q.pop_front());
         end
      end
   end

   task automatic push(input int c, input string n,
                       input logic [3:0] ph, input logic [1:0] a,
                       input logic [1:0] r, input logic tk);
      exp_t e;
      e.cyc = c; e.nm = n; e.ph = ph;
      e.act = a; e.req = r; e.tk = tk;
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CK);
      #1;
   endtask

   task automatic start_test();
      RST = 1'b1;
      clr = 1'b0;
      tgl = 2'b00;
      step(2);
      RST = 1'b0;
   endtask

   task automatic drain(input string n);
      for (int i = 0; i < 200 && q.size() != 0; i++)
         @(posedge CK);
      @(negedge CK);
      checks = checks + 1;
      if (q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL %s drain got %0d left want 0", n, q.size());
         q.delete();
      end
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      RST = 1'b1;
      clr = 1'b0;
      tgl = 2'b00;

      // Single request on ch0, then async reset mid-sequence.
      start_test();
      tgl = 2'b01;
      push(1,  "single", 4'b0000, 2'b00, 2'b01, 1'b0);
      push(3,  "single", 4'b0000, 2'b00, 2'b01, 1'b1);
      push(4,  "single", 4'b0001, 2'b01, 2'b01, 1'b0);
      push(11, "single", 4'b0001, 2'b01, 2'b01, 1'b1);
      push(12, "single", 4'b0010, 2'b01, 2'b01, 1'b0);
      push(16, "single", 4'b0011, 2'b01, 2'b01, 1'b0);
      push(19, "single", 4'b0011, 2'b01, 2'b01, 1'b1);
      push(20, "single", 4'b0000, 2'b00,
           CE ? 2'b00 : 2'b01, 1'b0);
      push(24, "single", CE ? 4'b0000 : 4'b0001,
           CE ? 2'b00 : 2'b01, CE ? 2'b00 : 2'b01, 1'b0);
      step(1);
      tgl = 2'b00;
      step(25);
      RST = 1'b1;
      push(0, "reset", 4'b0000, 2'b00, 2'b00, 1'b0);
      step(2);
      RST = 1'b0;
      push(2,  "rst_tick", 4'b0000, 2'b00, 2'b00, 1'b0);
      push(3,  "rst_tick", 4'b0000, 2'b00, 2'b00, 1'b1);
      push(7,  "rst_tick", 4'b0000, 2'b00, 2'b00, 1'b1);
      push(11, "rst_tick", 4'b0000, 2'b00, 2'b00, 1'b1);
      drain("single_reset");

      // Round-robin over both channels.
      start_test();
      tgl = 2'b11;
      push(4,  "rr", 4'b0001, 2'b01, 2'b11, 1'b0);
      push(19, "rr", 4'b0011, 2'b01, 2'b11, 1'b1);
      push(20, "rr", 4'b0000, 2'b00,
           CE ? 2'b10 : 2'b11, 1'b0);
      push(24, "rr", 4'b0100, 2'b10,
           CE ? 2'b10 : 2'b11, 1'b0);
      push(32, "rr", 4'b1000, 2'b10,
           CE ? 2'b10 : 2'b11, 1'b0);
      push(36, "rr", 4'b1100, 2'b10,
           CE ? 2'b10 : 2'b11, 1'b0);
      push(40, "rr", 4'b0000, 2'b00,
           CE ? 2'b00 : 2'b11, 1'b0);
      push(44, "rr", CE ? 4'b0000 : 4'b0001,
           CE ? 2'b00 : 2'b01, CE ? 2'b00 : 2'b11, 1'b0);
      step(1);
      tgl = 2'b00;
      drain("rr");

      // clr mid-YELLOW of ch1.
      start_test();
      tgl = 2'b10;
      push(4,  "clr_y", 4'b0100, 2'b10, 2'b10, 1'b0);
      push(12, "clr_y", 4'b1000, 2'b10, 2'b10, 1'b0);
      push(13, "clr_y", 4'b1000, 2'b10, 2'b10, 1'b0);
      push(14, "clr_y", 4'b0000, 2'b00, 2'b00, 1'b0);
      push(16, "clr_y", 4'b0000, 2'b00, 2'b00, 1'b0);
      push(17, "clr_y", 4'b0000, 2'b00, 2'b00, 1'b1);
      step(1);
      tgl = 2'b00;
      step(12);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      drain("clr_y");

      // clr beats tgl and masks tick; double toggle cancels.
      start_test();
      push(3, "clr_tgl", 4'b0000, 2'b00, 2'b00, 1'b0);
      push(4, "clr_tgl", 4'b0000, 2'b00, 2'b00, 1'b0);
      push(6, "dbl_tgl", 4'b0000, 2'b00, 2'b10, 1'b0);
      push(7, "dbl_tgl", 4'b0000, 2'b00, 2'b00, 1'b1);
      push(8, "dbl_tgl", 4'b0000, 2'b00, 2'b00, 1'b0);
      step(3);
      clr = 1'b1;
      tgl = 2'b01;
      step(1);
      clr = 1'b0;
      tgl = 2'b00;
      step(1);
      tgl = 2'b10;
      step(2);
      tgl = 2'b00;
      drain("clr_tgl");

      // Un-requesting an active channel does not abort it.
      start_test();
      tgl = 2'b01;
      push(6,  "no_abort", 4'b0001, 2'b01, 2'b00, 1'b0);
      push(12, "no_abort", 4'b0010, 2'b01, 2'b00, 1'b0);
      push(19, "no_abort", 4'b0011, 2'b01, 2'b00, 1'b1);
      push(20, "no_abort", 4'b0000, 2'b00, 2'b00, 1'b0);
      push(24, "no_abort", 4'b0000, 2'b00, 2'b00, 1'b0);
      step(1);
      tgl = 2'b00;
      step(4);
      tgl = 2'b01;
      step(1);
      tgl = 2'b00;
      drain("no_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
